hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the EX/MEM/WB forwarding logic. It detects the RAW hazards that forwarding cannot cover and generates pipeline stall and bubble controls.
- Keeps a registered shadow copy of in-flight destination info for the EX, MEM and WB stages.
- From that state and the instruction in ID it decides:
  - load-use stalls;
  - branch-in-ID operand stalls.
- Sits between the ID stage and the PC/IF-ID/ID-EX pipeline register enables. Also counts stall cycles for performance debug.

Parameters:
STALL_CNT_W, 16, width of the saturating stall-cycle counter
REG_AW, 5, register-number width (32 architectural registers; register 0 hardwired zero)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_AW  ID source register rs
id_rt  input  REG_AW  ID source register rt
id_usesRs  input  1  ID instruction reads rs
id_usesRt  input  1  ID instruction reads rt
id_isBranch  input  1  ID instruction is a branch compared in ID
id_dest  input  REG_AW  ID destination register (already muxed rd/rt)
id_regWrite  input  1  ID instruction writes the register file
id_memRead  input  1  ID instruction is a load
id_flush  input  1  kill the ID instruction (taken branch/jump)
pcWrite  output  1  PC update enable
ifIdWrite  output  1  IF/ID register enable
idExBubble  output  1  force ID/EX control signals to zero this cycle
stall  output  1  hazard stall active
stallCount  output  STALL_CNT_W  saturating count of stall cycles
ex_dest, mem_dest, wb_dest  output  REG_AW  shadow destination per stage (debug/forwarding cross-check)

Behaviour:
- Shadow entry per stage (EX, MEM, WB): {valid, dest, regWrite, memRead}.
- Match(S, r) means all of: S.valid, S.regWrite, S.dest==r, r!=0, and the corresponding id_uses* bit set.
- Hazard condition, combinational from registered state plus ID inputs (zero-cycle latency); requires id_valid and !id_flush:
  - Load-use: Match(EX, src) with EX.memRead, for src in {rs, rt}.
  - Branch-ALU: id_isBranch with Match(EX, src) and !EX.memRead.
  - Branch-load: id_isBranch with Match(MEM, src) and MEM.memRead.
  - Branch-load in EX is already covered by load-use. Total stall for a branch right after a load is 2 cycles.
  - WB-stage matches never stall; the register file writes first half and reads second half.
- stall = hazard. Control outputs:
  - pcWrite = !stall.
  - ifIdWrite = !stall.
  - idExBubble = stall | id_flush | !id_valid.
- Shadow update on each rising clk:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (valid=0) if idExBubble; otherwise {1, id_dest, id_regWrite, id_memRead}.
- stallCount increments by 1 each cycle stall=1. It saturates at all-ones and never wraps.
- Simultaneous id_flush and hazard: flush wins. stall=0, and the ID instruction enters EX as a bubble.
- Reset (async assert, any cycle, including mid-stall):
  - all shadow entries valid=0, dest=0, regWrite=0, memRead=0;
  - stallCount=0; stall=0; pcWrite=1; ifIdWrite=1; idExBubble=!id_valid.
- After reset deassertion, the first hazard can occur only once a real instruction reaches EX (one cycle minimum).
- Destination register 0 never causes a stall, even with regWrite=1.
- ex_dest/mem_dest/wb_dest output the stored dest field. They read 0 when the entry is a reset bubble; otherwise the stored value.

Test Plan:
- Load-use: lw $8 then add using rs=$8 → exactly 1 cycle stall=1, pcWrite=0, idExBubble=1. The next cycle stall=0 with add in EX. stallCount=1.
- Branch after ALU: add $9 then beq using rt=$9 → 1 stall cycle. Branch after lw $9 → 2 consecutive stall cycles. stallCount=2.
- No false hazards, each giving stall=0 throughout:
  - dest=$0 with regWrite=1;
  - regWrite=0 (sw to $8);
  - id_usesRt=0 with rt matching;
  - WB-only match.
- Flush priority: load-use hazard present with id_flush=1 → stall=0, pcWrite=1, idExBubble=1. The next cycle ex entry valid=0.
- Saturation: STALL_CNT_W=4, 20 forced load-use stalls → stallCount holds 15.
- Async reset: assert rst_n=0 mid-stall between clock edges → stall=0, stallCount=0, shadow cleared immediately. Release: no stall until a new load reaches EX.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Detects RAW hazards that forwarding cannot resolve and stalls PC/IF-ID while bubbling ID/EX.
// Keeps a shadow of EX/MEM/WB destinations and a saturating count of stall cycles.
module hazard_stall_unit #(
  parameter int STALL_CNT_W = 16,
  parameter int REG_AW      = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_usesRs,
  input  logic                   id_usesRt,
  input  logic                   id_isBranch,
  input  logic [REG_AW-1:0]      id_dest,
  input  logic                   id_regWrite,
  input  logic                   id_memRead,
  input  logic                   id_flush,
  output logic                   pcWrite,
  output logic                   ifIdWrite,
  output logic                   idExBubble,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stallCount,
  output logic [REG_AW-1:0]      ex_dest,
  output logic [REG_AW-1:0]      mem_dest,
  output logic [REG_AW-1:0]      wb_dest
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  shadow_t                r_ex;
  shadow_t                r_mem;
  shadow_t                r_wb;
  shadow_t                w_ex_next;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic w_ex_hit, w_mem_hit;
  logic w_load_use, w_br_alu, w_br_load, w_hazard;

  function automatic logic f_match(input shadow_t s, input logic [REG_AW-1:0] r,
                                   input logic uses);
    return s.valid & s.reg_write & (s.dest == r) & (r != '0) & uses;
  endfunction

  assign w_ex_rs   = f_match(r_ex,  id_rs, id_usesRs);
  assign w_ex_rt   = f_match(r_ex,  id_rt, id_usesRt);
  assign w_mem_rs  = f_match(r_mem, id_rs, id_usesRs);
  assign w_mem_rt  = f_match(r_mem, id_rt, id_usesRt);
  assign w_ex_hit  = w_ex_rs | w_ex_rt;
  assign w_mem_hit = w_mem_rs | w_mem_rt;

  // A load in EX also covers the branch-after-load case, giving two stall cycles in total.
  assign w_load_use = w_ex_hit & r_ex.mem_read;
  assign w_br_alu   = id_isBranch & w_ex_hit & ~r_ex.mem_read;
  assign w_br_load  = id_isBranch & w_mem_hit & r_mem.mem_read;
  assign w_hazard   = id_valid & ~id_flush & (w_load_use | w_br_alu | w_br_load);

  assign stall      = w_hazard;
  assign pcWrite    = ~w_hazard;
  assign ifIdWrite  = ~w_hazard;
  assign idExBubble = w_hazard | id_flush | ~id_valid;

  assign stallCount = r_stall_cnt;
  assign ex_dest    = r_ex.dest;
  assign mem_dest   = r_mem.dest;
  assign wb_dest    = r_wb.dest;

  // Bubbles are stored as all-zero entries so the debug dest outputs read 0 for them.
  always_comb begin
    w_ex_next = '0;
    if (!idExBubble) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.dest      = id_dest;
      w_ex_next.reg_write = id_regWrite;
      w_ex_next.mem_read  = id_memRead;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
      if (w_hazard && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, branch stalls, false-hazard filters,
// flush priority, asynchronous reset and counter saturation (4-bit counter instance).
module tb_hazard_stall_unit;

  localparam int CW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_usesRs, id_usesRt, id_isBranch, id_regWrite, id_memRead, id_flush;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          pcWrite, ifIdWrite, idExBubble, stall;
  logic [CW-1:0] stallCount;
  logic [AW-1:0] ex_dest, mem_dest, wb_dest;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_stall_unit #(.STALL_CNT_W(CW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_usesRs(id_usesRs), .id_usesRt(id_usesRt), .id_isBranch(id_isBranch),
    .id_dest(id_dest), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .id_flush(id_flush),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExBubble(idExBubble),
    .stall(stall), .stallCount(stallCount),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic br,
                        input logic [AW-1:0] dest, input logic rw, input logic mr,
                        input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_usesRs = urs; id_usesRt = urt;
    id_isBranch = br; id_dest = dest; id_regWrite = rw; id_memRead = mr; id_flush = fl;
    #1;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    nop();
    #3;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", stall); else n_pass++;
    n_checks++; if (pcWrite !== 1'b1) $display("FAIL rst_pcWrite: got %0b want 1", pcWrite); else n_pass++;
    n_checks++; if (ifIdWrite !== 1'b1) $display("FAIL rst_ifIdWrite: got %0b want 1", ifIdWrite); else n_pass++;
    n_checks++; if (idExBubble !== 1'b1) $display("FAIL rst_bubble_invalid: got %0b want 1", idExBubble); else n_pass++;
    n_checks++; if (stallCount !== 4'd0) $display("FAIL rst_count: got %0d want 0", stallCount); else n_pass++;
    n_checks++; if ({ex_dest, mem_dest, wb_dest} !== 15'd0) $display("FAIL rst_shadow: got %0d/%0d/%0d want 0/0/0", ex_dest, mem_dest, wb_dest); else n_pass++;
    set_id(1, 8, 8, 1, 1, 1, 8, 1, 1, 0);
    n_checks++; if (idExBubble !== 1'b0) $display("FAIL rst_bubble_valid: got %0b want 0", idExBubble); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_no_hazard: got %0b want 0", stall); else n_pass++;
    nop();
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    set_id(1, 29, 0, 1, 0, 0, 8, 1, 1, 0);                 // lw $8, 0($29)
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_pre: got %0b want 0", stall); else n_pass++;
    tick();
    set_id(1, 8, 9, 1, 1, 0, 10, 1, 0, 0);                 // add $10, $8, $9
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall: got %0b want 1", stall); else n_pass++;
    n_checks++; if (pcWrite !== 1'b0) $display("FAIL lu_pcWrite: got %0b want 0", pcWrite); else n_pass++;
    n_checks++; if (ifIdWrite !== 1'b0) $display("FAIL lu_ifIdWrite: got %0b want 0", ifIdWrite); else n_pass++;
    n_checks++; if (idExBubble !== 1'b1) $display("FAIL lu_bubble: got %0b want 1", idExBubble); else n_pass++;
    n_checks++; if (ex_dest !== 5'd8) $display("FAIL lu_ex_dest: got %0d want 8", ex_dest); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_release: got %0b want 0", stall); else n_pass++;
    n_checks++; if (ex_dest !== 5'd0 || mem_dest !== 5'd8) $display("FAIL lu_bubble_ex: got ex=%0d mem=%0d want 0/8", ex_dest, mem_dest); else n_pass++;
    tick();
    n_checks++; if (ex_dest !== 5'd10) $display("FAIL lu_add_in_ex: got %0d want 10", ex_dest); else n_pass++;
    n_checks++; if (stallCount !== 4'd1) $display("FAIL lu_count: got %0d want 1", stallCount); else n_pass++;
    drain();
    $display("test_load_use done count=%0d", stallCount);
  endtask

  task automatic test_branch();
    set_id(1, 1, 2, 1, 1, 0, 9, 1, 0, 0);                  // add $9, $1, $2
    tick();
    set_id(1, 4, 9, 1, 1, 1, 0, 0, 0, 0);                  // beq $4, $9
    n_checks++; if (stall !== 1'b1) $display("FAIL br_alu_stall: got %0b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b0) $display("FAIL br_alu_release: got %0b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (stallCount !== 4'd2) $display("FAIL br_alu_count: got %0d want 2", stallCount); else n_pass++;
    drain();
    set_id(1, 29, 0, 1, 0, 0, 9, 1, 1, 0);                 // lw $9
    tick();
    set_id(1, 4, 9, 1, 1, 1, 0, 0, 0, 0);                  // beq $4, $9
    n_checks++; if (stall !== 1'b1) $display("FAIL br_ld_stall1: got %0b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b1) $display("FAIL br_ld_stall2: got %0b want 1", stall); else n_pass++;
    n_checks++; if (mem_dest !== 5'd9) $display("FAIL br_ld_mem_dest: got %0d want 9", mem_dest); else n_pass++;
    tick();
    n_checks++; if (stall !== 1'b0) $display("FAIL br_ld_release: got %0b want 0", stall); else n_pass++;
    n_checks++; if (stallCount !== 4'd4) $display("FAIL br_ld_count: got %0d want 4", stallCount); else n_pass++;
    drain();
    $display("test_branch done count=%0d", stallCount);
  endtask

  task automatic test_no_false();
    set_id(1, 29, 0, 1, 0, 0, 0, 1, 1, 0);                 // lw $0
    tick();
    set_id(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);                  // beq $0, $0
    n_checks++; if (stall !== 1'b0) $display("FAIL nf_dest0: got %0b want 0", stall); else n_pass++;
    drain();
    set_id(1, 29, 8, 1, 1, 0, 8, 0, 0, 0);                 // sw $8
    tick();
    set_id(1, 8, 0, 1, 0, 1, 0, 0, 0, 0);                  // branch on $8
    n_checks++; if (stall !== 1'b0) $display("FAIL nf_nowrite: got %0b want 0", stall); else n_pass++;
    drain();
    set_id(1, 29, 0, 1, 0, 0, 8, 1, 1, 0);                 // lw $8
    tick();
    set_id(1, 3, 8, 1, 0, 1, 11, 1, 0, 0);                 // rt=$8 present but unused
    n_checks++; if (stall !== 1'b0) $display("FAIL nf_unused_rt: got %0b want 0", stall); else n_pass++;
    drain();
    set_id(1, 29, 0, 1, 0, 0, 8, 1, 1, 0);                 // lw $8
    tick();
    set_id(1, 1, 2, 1, 1, 0, 12, 1, 0, 0);
    tick();
    set_id(1, 1, 2, 1, 1, 0, 13, 1, 0, 0);
    tick();
    set_id(1, 8, 8, 1, 1, 1, 0, 0, 0, 0);                  // branch on $8, load now in WB
    n_checks++; if (wb_dest !== 5'd8) $display("FAIL nf_wb_dest: got %0d want 8", wb_dest); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL nf_wb_only: got %0b want 0", stall); else n_pass++;
    drain();
    n_checks++; if (stallCount !== 4'd4) $display("FAIL nf_count: got %0d want 4", stallCount); else n_pass++;
    $display("test_no_false done count=%0d", stallCount);
  endtask

  task automatic test_flush();
    set_id(1, 29, 0, 1, 0, 0, 8, 1, 1, 0);                 // lw $8
    tick();
    set_id(1, 8, 9, 1, 1, 0, 10, 1, 0, 1);                 // dependent add, flushed
    n_checks++; if (stall !== 1'b0) $display("FAIL fl_stall: got %0b want 0", stall); else n_pass++;
    n_checks++; if (pcWrite !== 1'b1) $display("FAIL fl_pcWrite: got %0b want 1", pcWrite); else n_pass++;
    n_checks++; if (idExBubble !== 1'b1) $display("FAIL fl_bubble: got %0b want 1", idExBubble); else n_pass++;
    tick();
    nop();
    n_checks++; if (ex_dest !== 5'd0 || mem_dest !== 5'd8) $display("FAIL fl_ex_bubble: got ex=%0d mem=%0d want 0/8", ex_dest, mem_dest); else n_pass++;
    drain();
    n_checks++; if (stallCount !== 4'd4) $display("FAIL fl_count: got %0d want 4", stallCount); else n_pass++;
    $display("test_flush done count=%0d", stallCount);
  endtask

  task automatic test_async_reset();
    set_id(1, 29, 0, 1, 0, 0, 8, 1, 1, 0);                 // lw $8
    tick();
    set_id(1, 8, 9, 1, 1, 0, 10, 1, 0, 0);                 // add $10, $8, $9
    n_checks++; if (stall !== 1'b1) $display("FAIL ar_pre_stall: got %0b want 1", stall); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL ar_stall: got %0b want 0", stall); else n_pass++;
    n_checks++; if (pcWrite !== 1'b1) $display("FAIL ar_pcWrite: got %0b want 1", pcWrite); else n_pass++;
    n_checks++; if (stallCount !== 4'd0) $display("FAIL ar_count: got %0d want 0", stallCount); else n_pass++;
    n_checks++; if (ex_dest !== 5'd0) $display("FAIL ar_ex_dest: got %0d want 0", ex_dest); else n_pass++;
    #2 rst_n = 1'b1;
    tick();
    n_checks++; if (stall !== 1'b0 || ex_dest !== 5'd10) $display("FAIL ar_after: got stall=%0b ex=%0d want 0/10", stall, ex_dest); else n_pass++;
    set_id(1, 29, 0, 1, 0, 0, 8, 1, 1, 0);                 // new lw $8
    tick();
    set_id(1, 8, 9, 1, 1, 0, 10, 1, 0, 0);
    n_checks++; if (stall !== 1'b1) $display("FAIL ar_new_load: got %0b want 1", stall); else n_pass++;
    tick();
    n_checks++; if (stallCount !== 4'd1) $display("FAIL ar_new_count: got %0d want 1", stallCount); else n_pass++;
    drain();
    $display("test_async_reset done count=%0d", stallCount);
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    set_id(1, 8, 0, 1, 0, 0, 8, 1, 1, 0);                  // lw $8, 0($8) repeated: stalls every other cycle
    repeat (28) tick();
    n_checks++; if (stallCount !== 4'd14) $display("FAIL sat_14: got %0d want 14", stallCount); else n_pass++;
    repeat (12) tick();
    n_checks++; if (stallCount !== 4'd15) $display("FAIL sat_hold: got %0d want 15", stallCount); else n_pass++;
    drain();
    $display("test_saturation done count=%0d", stallCount);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_no_false();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
